// File: rtl/picorv32_arb_pkg.sv
// Shared types and constants for the two-port PicoRV32 memory arbiter.
// Imported by picorv32_mem_arbiter and picorv32_arb_wdog.
package picorv32_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int WDOG_WIDTH             = 16;

endpackage

// File: rtl/picorv32_arb_wdog.sv
// Grant watchdog: counts stalled grant cycles and flags when the count reaches limit.
// Body exists only when PICORV32_ARB_TIMEOUT_EN is defined.
`ifdef PICORV32_ARB_TIMEOUT_EN
module picorv32_arb_wdog
    import picorv32_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [WDOG_WIDTH-1:0] limit,
    output logic                  expire
);

    logic [WDOG_WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WDOG_WIDTH'(1);
        end
    end

    assign expire = (count == limit);

endmodule
`endif

// File: rtl/picorv32_mem_arbiter.sv
// Two-port round-robin arbiter sharing one PicoRV32 native memory interface.
// Optional grant watchdog enabled by defining PICORV32_ARB_TIMEOUT_EN.
module picorv32_mem_arbiter
    import picorv32_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,

    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,

    output logic        timeout_irq
);

    arb_state_t state, state_next;
    logic       last_grant, last_grant_next;
    logic       timeout;
    logic       done;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    assign done = mem_ready || timeout;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        mem_valid       = 1'b0;
        mem_instr       = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        mem_wstrb       = '0;
        m0_mem_ready    = 1'b0;
        m1_mem_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (m0_mem_valid && m1_mem_valid) begin
                    state_next = last_grant ? GRANT0 : GRANT1;
                end else if (m0_mem_valid) begin
                    state_next = GRANT0;
                end else if (m1_mem_valid) begin
                    state_next = GRANT1;
                end
            end
            GRANT0: begin
                mem_valid    = 1'b1;
                mem_instr    = m0_mem_instr;
                mem_addr     = m0_mem_addr;
                mem_wdata    = m0_mem_wdata;
                mem_wstrb    = m0_mem_wstrb;
                m0_mem_ready = done;
                if (done) begin
                    state_next      = IDLE;
                    last_grant_next = 1'b0;
                end
            end
            GRANT1: begin
                mem_valid    = 1'b1;
                mem_instr    = m1_mem_instr;
                mem_addr     = m1_mem_addr;
                mem_wdata    = m1_mem_wdata;
                mem_wstrb    = m1_mem_wstrb;
                m1_mem_ready = done;
                if (done) begin
                    state_next      = IDLE;
                    last_grant_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A watchdog completion returns zero data to the granted port only.
    assign m0_mem_rdata = (timeout && state == GRANT0) ? 32'h0000_0000 : mem_rdata;
    assign m1_mem_rdata = (timeout && state == GRANT1) ? 32'h0000_0000 : mem_rdata;
    assign timeout_irq  = timeout;

`ifdef PICORV32_ARB_TIMEOUT_EN
    logic in_grant;
    logic wdog_expire;

    assign in_grant = (state != IDLE);

    picorv32_arb_wdog u_wdog (
        .clk    (clk),
        .resetn (resetn),
        .clear  (!in_grant),
        .enable (in_grant && !mem_ready),
        .limit  (WDOG_WIDTH'(TIMEOUT_CYCLES)),
        .expire (wdog_expire)
    );

    // A real completion on the expiry cycle takes precedence over the watchdog.
    assign timeout = in_grant && wdog_expire && !mem_ready;
`else
    logic [WDOG_WIDTH-1:0] unused_timeout_cycles;

    assign unused_timeout_cycles = WDOG_WIDTH'(TIMEOUT_CYCLES);
    assign timeout               = 1'b0;
`endif

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Self-checking bench for picorv32_mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transfer-level reference model.
module tb_picorv32_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_mem_valid, m0_mem_instr, m0_mem_ready;
    logic [31:0] m0_mem_addr, m0_mem_wdata, m0_mem_rdata;
    logic [3:0]  m0_mem_wstrb;
    logic        m1_mem_valid, m1_mem_instr, m1_mem_ready;
    logic [31:0] m1_mem_addr, m1_mem_wdata, m1_mem_rdata;
    logic [3:0]  m1_mem_wstrb;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        timeout_irq;

    always #5 clk = ~clk;

    picorv32_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .m0_mem_valid (m0_mem_valid),
        .m0_mem_instr (m0_mem_instr),
        .m0_mem_addr  (m0_mem_addr),
        .m0_mem_wdata (m0_mem_wdata),
        .m0_mem_wstrb (m0_mem_wstrb),
        .m0_mem_ready (m0_mem_ready),
        .m0_mem_rdata (m0_mem_rdata),
        .m1_mem_valid (m1_mem_valid),
        .m1_mem_instr (m1_mem_instr),
        .m1_mem_addr  (m1_mem_addr),
        .m1_mem_wdata (m1_mem_wdata),
        .m1_mem_wstrb (m1_mem_wstrb),
        .m1_mem_ready (m1_mem_ready),
        .m1_mem_rdata (m1_mem_rdata),
        .mem_valid    (mem_valid),
        .mem_instr    (mem_instr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .timeout_irq  (timeout_irq)
    );

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    // Requester and memory model state
    req_t        rq [2];
    int          gap [2];
    int          mode       = 0;   // 0 directed, 1 continuous, 2 random
    int          owner      = -1;  // port currently holding the bus, -1 when free
    int          last       = 1;
    int          wait_cnt   = 0;
    int          lat        = 0;
    int          forced_lat = -1;
    bit          chk_en     = 1'b0;
    bit          use_fixed  = 1'b0;
    logic [31:0] fixed_rd   = 32'h0;

    // Observations from the DUT
    int          done_log [$];
    logic [31:0] last_rdata [2];
    int          irq_count  = 0;

    int          n_checks   = 0;
    int          n_fail     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic req_t mk_req(input logic instr, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] wstrb);
        return '{1'b1, instr, addr, wdata, wstrb};
    endfunction

    function automatic req_t rand_req();
        logic [3:0] strb;
        strb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        return mk_req(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, strb);
    endfunction

    function automatic void finish_req(input int p);
        case (mode)
            0: rq[p].valid = 1'b0;
            1: rq[p] = rand_req();
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    rq[p] = rand_req();
                end else begin
                    rq[p].valid = 1'b0;
                    gap[p] = int'($urandom_range(0, 4));
                end
            end
        endcase
    endfunction

    // One clock cycle: drive inputs, compare outputs at negedge, advance the model after posedge.
    task automatic step(input logic rst_n);
        logic        rdy, tmo, comp;
        logic [31:0] rd;
        logic [1:0]  drv_valid;
        if (owner >= 0) rdy = (lat == 0);
        else            rdy = 1'($urandom_range(0, 1));
        rd  = use_fixed ? fixed_rd : $urandom;
        tmo = 1'b0;
`ifdef PICORV32_ARB_TIMEOUT_EN
        tmo = (owner >= 0) && !rdy && (wait_cnt == TMO);
`endif
        comp = (owner >= 0) && (rdy || tmo);
        for (int p = 0; p < 2; p++)
            drv_valid[p] = rq[p].valid && !(mode == 2 && owner == p && $urandom_range(0, 3) == 0);

        resetn       = rst_n;
        m0_mem_valid = drv_valid[0];
        m0_mem_instr = rq[0].instr;
        m0_mem_addr  = rq[0].addr;
        m0_mem_wdata = rq[0].wdata;
        m0_mem_wstrb = rq[0].wstrb;
        m1_mem_valid = drv_valid[1];
        m1_mem_instr = rq[1].instr;
        m1_mem_addr  = rq[1].addr;
        m1_mem_wdata = rq[1].wdata;
        m1_mem_wstrb = rq[1].wstrb;
        mem_ready    = rdy;
        mem_rdata    = rd;

        @(negedge clk);
        if (chk_en) begin
            check("mem_valid", 32'(mem_valid), 32'(owner >= 0));
            if (owner >= 0) begin
                check("mem_instr", 32'(mem_instr), 32'(rq[owner].instr));
                check("mem_addr",  mem_addr,       rq[owner].addr);
                check("mem_wdata", mem_wdata,      rq[owner].wdata);
                check("mem_wstrb", 32'(mem_wstrb), 32'(rq[owner].wstrb));
            end
            check("m0_ready",    32'(m0_mem_ready), 32'(owner == 0 && comp));
            check("m1_ready",    32'(m1_mem_ready), 32'(owner == 1 && comp));
            check("m0_rdata",    m0_mem_rdata, (owner == 0 && tmo) ? 32'h0 : rd);
            check("m1_rdata",    m1_mem_rdata, (owner == 1 && tmo) ? 32'h0 : rd);
            check("timeout_irq", 32'(timeout_irq), 32'(tmo));
        end
        if (m0_mem_ready === 1'b1) begin done_log.push_back(0); last_rdata[0] = m0_mem_rdata; end
        if (m1_mem_ready === 1'b1) begin done_log.push_back(1); last_rdata[1] = m1_mem_rdata; end
        if (timeout_irq === 1'b1) irq_count++;

        @(posedge clk);
        #1;
        if (!rst_n) begin
            owner = -1;
            last  = 1;
        end else if (owner < 0) begin
            if (drv_valid[0] && drv_valid[1]) owner = (last == 0) ? 1 : 0;
            else if (drv_valid[0])            owner = 0;
            else if (drv_valid[1])            owner = 1;
            if (owner >= 0) begin
                wait_cnt = 0;
                lat = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 7));
            end
        end else if (comp) begin
            last = owner;
            finish_req(owner);
            owner = -1;
        end else begin
            wait_cnt++;
            if (lat > 0) lat--;
        end
        for (int p = 0; p < 2; p++) begin
            if (!rq[p].valid && mode != 0) begin
                if (gap[p] > 0) gap[p]--;
                else            rq[p] = rand_req();
            end
        end
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int cyc = 0;
        while (done_log.size() < n && cyc < budget) begin
            step(1'b1);
            cyc++;
        end
        check({tag, "_done_count"}, 32'(done_log.size()), 32'(n));
    endtask

    task automatic drain();
        int cyc = 0;
        mode = 0;
        forced_lat = 1;
        while ((owner >= 0 || rq[0].valid || rq[1].valid) && cyc < 60) begin
            step(1'b1);
            cyc++;
        end
        check("drain_idle", 32'(owner >= 0 || rq[0].valid || rq[1].valid), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rq[0] = '0;
        rq[1] = '0;
        gap[0] = 0;
        gap[1] = 0;
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        step(1'b0);
        step(1'b0);
        chk_en = 1'b1;

        // Reset state
        check("rst_mem_valid",   32'(mem_valid),    32'(0));
        check("rst_m0_ready",    32'(m0_mem_ready), 32'(0));
        check("rst_m1_ready",    32'(m1_mem_ready), 32'(0));
        check("rst_timeout_irq", 32'(timeout_irq),  32'(0));

        // Single read by m0
        done_log.delete();
        rq[0] = mk_req(1'b0, 32'h0000_1000, 32'h0, 4'h0);
        forced_lat = 3;
        use_fixed = 1'b1;
        fixed_rd = 32'hCAFE_F00D;
        run_until(1, 20, "t1");
        repeat (3) step(1'b1);
        check("t1_ready_pulses", 32'(done_log.size()), 32'(1));
        if (done_log.size() > 0) check("t1_port", 32'(done_log[0]), 32'(0));
        check("t1_rdata", last_rdata[0], 32'hCAFE_F00D);
        use_fixed = 1'b0;
        drain();

        // Simultaneous requests right after reset: m0 first, then m1
        step(1'b0);
        done_log.delete();
        rq[0] = mk_req(1'b0, 32'h0000_0010, 32'h1234_5678, 4'hF);
        rq[1] = mk_req(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        forced_lat = 1;
        run_until(2, 20, "t2");
        if (done_log.size() >= 2) begin
            check("t2_first",  32'(done_log[0]), 32'(0));
            check("t2_second", 32'(done_log[1]), 32'(1));
        end
        drain();

        // Sustained contention alternates 0,1,0,1,...
        done_log.delete();
        mode = 1;
        forced_lat = -1;
        rq[0] = rand_req();
        rq[1] = rand_req();
        run_until(8, 200, "t3");
        if (done_log.size() >= 8)
            for (int i = 0; i < 8; i++)
                check($sformatf("t3_grant%0d", i), 32'(done_log[i]), 32'(i % 2));
        drain();

        // Reset while m1 holds the bus with ready withheld
        done_log.delete();
        forced_lat = 100;
        rq[1] = mk_req(1'b1, 32'h0000_0040, 32'h0, 4'h0);
        for (int i = 0; i < 10 && owner != 1; i++) step(1'b1);
        check("t4_granted_m1", 32'(owner), 32'(1));
        step(1'b1);
        step(1'b1);
        rq[0] = mk_req(1'b0, 32'h0000_0080, 32'h0, 4'h0);
        rq[1] = mk_req(1'b0, 32'h0000_0084, 32'h0, 4'h0);
        step(1'b0);
        check("t4_mem_valid_after_rst", 32'(mem_valid), 32'(0));
        check("t4_no_ready", 32'(done_log.size()), 32'(0));
        forced_lat = 1;
        run_until(2, 20, "t4");
        if (done_log.size() >= 2) check("t4_tie_winner", 32'(done_log[0]), 32'(0));
        drain();

`ifdef PICORV32_ARB_TIMEOUT_EN
        // Watchdog expiry with ready never asserted
        done_log.delete();
        irq_count = 0;
        use_fixed = 1'b1;
        fixed_rd = 32'hDEAD_BEEF;
        forced_lat = 100;
        rq[1] = mk_req(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        run_until(1, 20, "t5");
        check("t5_rdata_zero", last_rdata[1], 32'h0);
        check("t5_irq_count", 32'(irq_count), 32'(1));
        drain();

        // Ready on the expiry cycle wins over the watchdog
        done_log.delete();
        irq_count = 0;
        forced_lat = TMO;
        rq[1] = mk_req(1'b0, 32'h0000_0104, 32'h0, 4'h0);
        run_until(1, 20, "t6");
        check("t6_rdata_real", last_rdata[1], 32'hDEAD_BEEF);
        check("t6_irq_count", 32'(irq_count), 32'(0));
        use_fixed = 1'b0;
        drain();
`else
        // Without the watchdog a long stall just waits
        done_log.delete();
        irq_count = 0;
        forced_lat = 30;
        rq[0] = mk_req(1'b0, 32'h0000_0200, 32'h0, 4'h0);
        repeat (25) step(1'b1);
        check("t5_still_waiting", 32'(done_log.size()), 32'(0));
        run_until(1, 40, "t5");
        check("t5_irq_count", 32'(irq_count), 32'(0));
        drain();
`endif

        // Randomized traffic
        mode = 2;
        forced_lat = -1;
        rq[0] = rand_req();
        rq[1] = rand_req();
        repeat (500) step(1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
